// File: rtl/phy_pkg.sv
// rtl/phy_pkg.sv - shared lane-mode encodings, idle symbol and active-lane helper
package phy_pkg;

   typedef enum logic [1:0] {
      MODE_X1   = 2'd0,
      MODE_X2   = 2'd1,
      MODE_X4   = 2'd2,
      MODE_RSVD = 2'd3
   } lane_mode_e;

   localparam logic [7:0] IDLE_SYM_DEFAULT = 8'h00;

   // Reserved and oversize encodings clamp down to what the lanes and the word can carry.
   function automatic int active_lanes(input logic [1:0] mode, input int lanes, input int bytes);
      int a;
      case (lane_mode_e'(mode))
         MODE_X2: a = 2;
         MODE_X4: a = 4;
         default: a = 1;
      endcase
      if (a > lanes) a = lanes;
      if (a > bytes) a = bytes;
      return a;
   endfunction

endpackage

// File: rtl/phy_word_fifo.sv
// rtl/phy_word_fifo.sv - input word FIFO with occupancy level for the lane striper
module phy_word_fifo
   import phy_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic                         pop,
   input  logic [DATA_W-1:0]            wdata,
   output logic [DATA_W-1:0]            rdata,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [LW-1:0]     level_q;
   logic              do_push;
   logic              do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (level_q == LW'(DEPTH));
   assign empty   = (level_q == '0);
   assign level   = level_q;
   assign rdata   = mem_q[rd_ptr_q];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   // Storage carries no reset; validity is tracked by the pointers and level alone.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/phy_lane_striper.sv
// rtl/phy_lane_striper.sv - buffers words and stripes their bytes round-robin over 1/2/4 lanes
module phy_lane_striper
   import phy_pkg::*;
#(
   parameter int         DATA_W     = 32,
   parameter int         LANES      = 4,
   parameter int         FIFO_DEPTH = 4,
   parameter logic [7:0] IDLE_SYM   = IDLE_SYM_DEFAULT
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [DATA_W-1:0]                   data_in,
   input  logic                                valid_in,
   output logic                                ready_out,
   input  logic [1:0]                          lane_mode,
   output logic [LANES*8-1:0]                  data_out,
   output logic [LANES-1:0]                    valid_out,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level,
   output logic [1:0]                          mode_active
);

   localparam int BYTES = DATA_W / 8;
   localparam int BP_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int LW    = $clog2(FIFO_DEPTH + 1);
   localparam int OUT_W = LANES * 8;

   logic [DATA_W-1:0] fifo_rdata;
   logic              fifo_full;
   logic              fifo_empty;
   logic [LW-1:0]     fifo_level_c;
   logic [LW-1:0]     level_next_c;
   logic              push_c;
   logic              pop_c;

   logic              ready_q,  ready_d;
   logic              busy_q,   busy_d;
   logic [DATA_W-1:0] word_q,   word_d;
   logic [BP_W-1:0]   bp_q,     bp_d;
   logic [1:0]        mode_q,   mode_d;
   logic [OUT_W-1:0]  data_q,   data_d;
   logic [LANES-1:0]  valid_q,  valid_d;

   int                act_i;
   int                bp_next_i;
   logic [OUT_W-1:0]  shift_c;

   phy_word_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_c),
      .pop   (pop_c),
      .wdata (data_in),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level_c)
   );

   // ready_out is a register, so it tracks the FIFO level one edge ahead of the push it gates.
   assign push_c       = valid_in && ready_q;
   assign level_next_c = fifo_level_c + LW'(push_c) - LW'(pop_c);
   assign ready_d      = (level_next_c != LW'(FIFO_DEPTH));

   assign act_i     = active_lanes(mode_q, LANES, BYTES);
   assign bp_next_i = int'(bp_q) + act_i;
   assign shift_c   = OUT_W'(word_q >> {bp_q, 3'b000});

   always_comb begin
      busy_d  = busy_q;
      word_d  = word_q;
      bp_d    = bp_q;
      mode_d  = mode_q;
      pop_c   = 1'b0;
      data_d  = {LANES{IDLE_SYM}};
      valid_d = '0;
      if (busy_q) begin
         for (int l = 0; l < LANES; l++) begin
            if (l < act_i) begin
               data_d[8*l +: 8] = shift_c[8*l +: 8];
               valid_d[l]       = 1'b1;
            end
         end
         if (bp_next_i == BYTES) begin
            bp_d = '0;
            if (!fifo_empty) begin
               pop_c  = 1'b1;
               word_d = fifo_rdata;
            end else begin
               busy_d = 1'b0;
            end
         end else begin
            bp_d = BP_W'(bp_next_i);
         end
      end else if (!fifo_empty) begin
         pop_c  = 1'b1;
         busy_d = 1'b1;
         word_d = fifo_rdata;
         bp_d   = '0;
      end else if (!push_c) begin
         // Mode only moves when nothing is queued or in flight, so no word spans two modes.
         mode_d = lane_mode;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         word_q  <= '0;
         bp_q    <= '0;
         mode_q  <= MODE_X1;
         data_q  <= {LANES{IDLE_SYM}};
         valid_q <= '0;
      end else begin
         ready_q <= ready_d;
         busy_q  <= busy_d;
         word_q  <= word_d;
         bp_q    <= bp_d;
         mode_q  <= mode_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign ready_out   = ready_q;
   assign data_out    = data_q;
   assign valid_out   = valid_q;
   assign fifo_level  = fifo_level_c;
   assign mode_active = mode_q;

endmodule
